// File: rtl/gate_tt_pkg.sv
// Shared definitions for the logic-gate truth-table sequencer: function bit
// indices, FSM states and the golden gate model.
package gate_tt_pkg;

  localparam int GT_AND  = 0;
  localparam int GT_OR   = 1;
  localparam int GT_NOT  = 2;
  localparam int GT_NAND = 3;
  localparam int GT_NOR  = 4;
  localparam int GT_XOR  = 5;
  localparam int GT_XNOR = 6;
  localparam int GT_NUM  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } gt_state_t;

  function automatic logic [GT_NUM-1:0] gt_expected(input logic a, input logic b);
    logic [GT_NUM-1:0] e;
    e          = '0;
    e[GT_AND]  = a & b;
    e[GT_OR]   = a | b;
    e[GT_NOT]  = ~a;
    e[GT_NAND] = ~(a & b);
    e[GT_NOR]  = ~(a | b);
    e[GT_XOR]  = a ^ b;
    e[GT_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_tt_sequencer.sv
// Sweeps gate inputs a/b through 00,01,10,11, samples gate_out after a settle
// delay, and records the truth table, a sticky per-function error mask and pass.
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GT_NUM-1:0]   gate_out,
  output logic                a_drv,
  output logic                b_drv,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [1:0]          vec_idx,
  output logic [4*GT_NUM-1:0] table_out,
  output logic [GT_NUM-1:0]   err_mask
);

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  gt_state_t           state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          vec_q, vec_d;
  logic [4*GT_NUM-1:0] tbl_q, tbl_d;
  logic [GT_NUM-1:0]   err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [GT_NUM-1:0]   err_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    // Drives are the index bits themselves, so expected() uses the applied vector.
    err_new = err_q | (gate_out ^ gt_expected(vec_q[1], vec_q[0]));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_INIT;
          vec_d   = 2'd0;
          tbl_d   = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (vec_q == 2'(k)) tbl_d[k*GT_NUM +: GT_NUM] = gate_out;
          end
          err_d = err_new;
          if (vec_q == 2'd3) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_new == '0);
          end else begin
            vec_d = vec_q + 2'd1;
            cnt_d = CNT_INIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_drv     = vec_q[1];
  assign b_drv     = vec_q[0];
  assign vec_idx   = vec_q;
  assign table_out = tbl_q;
  assign err_mask  = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench: stimulus pushes expected sweep results, per-DUT monitors
// pop and compare on each rising edge of done.
module tb_gate_tt_sequencer;
  import gate_tt_pkg::*;

  typedef struct {
    int          done_cyc;
    logic        pass;
    logic [6:0]  err;
    logic [27:0] tbl;
  } exp_t;

  localparam logic [27:0] TBL_GOOD  = 28'h86A975C;
  localparam logic [27:0] TBL_XOR0  = 28'h862875C;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start1;
  logic [6:0]  stuck0;
  logic [6:0]  g4, g1;
  logic        a4, b4, busy4, done4, pass4;
  logic        a1, b1, busy1, done1, pass1;
  logic [1:0]  vec4, vec1;
  logic [27:0] tbl4, tbl1;
  logic [6:0]  err4, err1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic d4_prev = 1'b0;
  logic d1_prev = 1'b0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign g4 = gt_expected(a4, b4) & ~stuck0;
  assign g1 = gt_expected(a1, b1);

  gate_tt_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .gate_out(g4),
    .a_drv(a4), .b_drv(b4), .busy(busy4), .done(done4), .pass(pass4),
    .vec_idx(vec4), .table_out(tbl4), .err_mask(err4)
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_out(g1),
    .a_drv(a1), .b_drv(b1), .busy(busy1), .done(done1), .pass(pass1),
    .vec_idx(vec1), .table_out(tbl1), .err_mask(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic go4(input logic p, input logic [6:0] e, input logic [27:0] t, output int e0);
    exp_t x;
    e0 = cyc + 1;
    x.done_cyc = e0 + 16; x.pass = p; x.err = e; x.tbl = t;
    q4.push_back(x);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", q4.size() + q1.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done4 && !d4_prev) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done4 actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q4.pop_front();
        chk("done_cyc4", cyc, e.done_cyc);
        chk("pass4", {31'd0, pass4}, {31'd0, e.pass});
        chk("err_mask4", {25'd0, err4}, {25'd0, e.err});
        chk("table4", {4'd0, tbl4}, {4'd0, e.tbl});
        chk("busy_at_done4", {31'd0, busy4}, 32'd0);
        chk("ab_hold4", {30'd0, a4, b4}, 32'd3);
      end
    end
    d4_prev = done4;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1 && !d1_prev) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done1 actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("done_cyc1", cyc, e.done_cyc);
        chk("pass1", {31'd0, pass1}, {31'd0, e.pass});
        chk("err_mask1", {25'd0, err1}, {25'd0, e.err});
        chk("table1", {4'd0, tbl1}, {4'd0, e.tbl});
      end
    end
    d1_prev = done1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   e0;
    exp_t x;
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0; stuck0 = 7'h00;
    #3;
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_pass", {31'd0, pass4}, 32'd0);
    chk("rst_ab", {30'd0, a4, b4}, 32'd0);
    chk("rst_vec", {30'd0, vec4}, 32'd0);
    chk("rst_table", {4'd0, tbl4}, 32'd0);
    chk("rst_err", {25'd0, err4}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Healthy gates, S=4.
    go4(1'b1, 7'h00, TBL_GOOD, e0);
    chk("busy_after_start", {31'd0, busy4}, 32'd1);
    drain();

    // XOR output stuck at 0.
    stuck0 = 7'h20;
    go4(1'b0, 7'b0100000, TBL_XOR0, e0);
    drain();
    stuck0 = 7'h00;

    // S=1 drive sequence on consecutive cycles.
    e0 = cyc + 1;
    x.done_cyc = e0 + 4; x.pass = 1'b1; x.err = 7'h00; x.tbl = TBL_GOOD;
    q1.push_back(x);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("s1_ab_seq", {30'd0, a1, b1}, 32'(k));
      if (k < 3) @(negedge clk);
    end
    drain();

    // Re-pulsed start mid-sweep must not disturb completion time.
    go4(1'b1, 7'h00, TBL_GOOD, e0);
    repeat (2) @(negedge clk);
    start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    repeat (3) @(negedge clk);
    start4 = 1'b1; @(negedge clk); start4 = 1'b0;
    drain();

    // Reset mid-sweep clears everything asynchronously.
    go4(1'b1, 7'h00, TBL_GOOD, e0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    q4.delete();
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    chk("midrst_ab", {30'd0, a4, b4}, 32'd0);
    chk("midrst_vec", {30'd0, vec4}, 32'd0);
    chk("midrst_table", {4'd0, tbl4}, 32'd0);
    chk("midrst_err", {25'd0, err4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {30'd0, busy4, done4}, 32'd0);
    go4(1'b1, 7'h00, TBL_GOOD, e0);
    drain();

    // start held high for 40 edges: back-to-back sweeps, done one cycle each.
    e0 = cyc + 1;
    for (int s = 0; s < 3; s++) begin
      x.done_cyc = e0 + 16 + 17 * s; x.pass = 1'b1; x.err = 7'h00; x.tbl = TBL_GOOD;
      q4.push_back(x);
    end
    start4 = 1'b1;
    while (cyc < e0 + 17) @(negedge clk);
    chk("held_done_width", {31'd0, done4}, 32'd0);
    chk("held_busy_restart", {31'd0, busy4}, 32'd1);
    chk("held_table_clear", {4'd0, tbl4}, 32'd0);
    while (cyc < e0 + 39) @(negedge clk);
    start4 = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
